alu_cmd_queue: RTL and testbench

ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

---
 rtl/alu_cmd_queue.sv | 139 +++++++++++++
 tb/tb_alu_cmd_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding a combinational ALU, with a one-entry result register and divide-by-zero guard.
// Optional issued-command statistics counter enabled by defining ALU_CMD_QUEUE_STATS_EN.
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_A,
    input  logic [7:0]  cmd_B,
    input  logic [3:0]  cmd_Sel,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [3:0]  ALU_Sel,
    input  logic [7:0]  ALU_Out,
    input  logic        CarryOut,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_Out,
    output logic        res_Carry,
    output logic [3:0]  res_Sel,
    output logic        res_DivZero,
    output logic [15:0] cmd_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [3:0]       OP_DIV   = 4'b0011;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] b;
        logic [7:0] a;
    } cmd_t;

    typedef enum logic {IDLE, HOLD} state_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             push;
    logic             issue;
    logic             div_zero;
    state_t           state;
    state_t           state_next;

    assign empty     = (count == '0);
    assign cmd_ready = (count < CNT_FULL);
    assign push      = cmd_valid && cmd_ready;
    assign issue     = !empty && ((state == IDLE) || res_ready);
    assign head      = mem[rd_ptr];

    assign A        = empty ? 8'd0 : head.a;
    assign B        = empty ? 8'd0 : head.b;
    assign ALU_Sel  = empty ? 4'd0 : head.sel;
    assign div_zero = (ALU_Sel == OP_DIV) && (B == 8'd0);

    // NOTE: storage has no reset; count alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{sel: cmd_Sel, b: cmd_B, a: cmd_A};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({push, issue})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (issue) begin
            state_next = HOLD;
        end else if ((state == HOLD) && res_ready) begin
            state_next = IDLE;
        end
    end

    assign res_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_Out     <= 8'd0;
            res_Carry   <= 1'b0;
            res_Sel     <= 4'd0;
            res_DivZero <= 1'b0;
        end else if (issue) begin
            res_Sel     <= ALU_Sel;
            res_DivZero <= div_zero;
            res_Out     <= div_zero ? 8'hFF : ALU_Out;
            res_Carry   <= div_zero ? 1'b0 : CarryOut;
        end
    end

`ifdef ALU_CMD_QUEUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_count <= 16'd0;
        end else if (issue) begin
            cmd_count <= cmd_count + 16'd1;
        end
    end
`else
    assign cmd_count = 16'd0;
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: bench-side ALU, scoreboard of expected results, directed steps.
module tb_alu_cmd_queue;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] out;
        logic       carry;
        logic       dz;
    } res_t;

`ifdef ALU_CMD_QUEUE_STATS_EN
    localparam int EXP_COUNT = 10;
`else
    localparam int EXP_COUNT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_A;
    logic [7:0]  cmd_B;
    logic [3:0]  cmd_Sel;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_Sel;
    logic [7:0]  ALU_Out;
    logic        CarryOut;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_Out;
    logic        res_Carry;
    logic [3:0]  res_Sel;
    logic        res_DivZero;
    logic [15:0] cmd_count;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    alu_cmd_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_Sel(cmd_Sel),
        .A(A), .B(B), .ALU_Sel(ALU_Sel),
        .ALU_Out(ALU_Out), .CarryOut(CarryOut),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_Out(res_Out), .res_Carry(res_Carry), .res_Sel(res_Sel),
        .res_DivZero(res_DivZero), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    // Environment ALU: {carry, result}; divide by zero yields junk the queue must ignore.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        case (sel)
            4'd0:    alu_fn = {1'b0, a} + {1'b0, b};
            4'd1:    alu_fn = {1'b0, a} - {1'b0, b};
            4'd2:    alu_fn = {|prod[15:8], prod[7:0]};
            4'd3:    alu_fn = (b != 8'd0) ? {1'b1, a / b} : {1'b1, 8'h5A};
            4'd4:    alu_fn = {1'b0, a & b};
            4'd5:    alu_fn = {1'b0, a | b};
            4'd6:    alu_fn = {1'b0, a ^ b};
            default: alu_fn = {1'b0, ~a};
        endcase
    endfunction

    function automatic res_t ref_result(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        res_t       r;
        logic [8:0] v;
        r.sel = sel;
        if (sel == 4'b0011 && b == 8'd0) begin
            r.out   = 8'hFF;
            r.carry = 1'b0;
            r.dz    = 1'b1;
        end else begin
            v       = alu_fn(a, b, sel);
            r.out   = v[7:0];
            r.carry = v[8];
            r.dz    = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        {CarryOut, ALU_Out} = alu_fn(A, B, ALU_Sel);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes seen just before the edge, then move to the next falling edge.
    task automatic tick();
        res_t e;
        #1;
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_result", 32'(res_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", 32'({res_Sel, res_Out, res_Carry, res_DivZero}), 32'(e));
            end
        end
        if (cmd_valid && cmd_ready) begin
            sb.push_back(ref_result(cmd_A, cmd_B, cmd_Sel));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_A     = a;
        cmd_B     = b;
        cmd_Sel   = sel;
    endtask

    // Drain with res_ready high; each pending result must be presented back-to-back.
    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            #1 chk("throughput_valid", 32'(res_valid), 32'd1);
            tick();
            n++;
        end
        chk("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_A = 8'd0;
        cmd_B = 8'd0;
        cmd_Sel = 4'd0;
        res_ready = 1'b0;
        #1 chk("rst_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_operands", 32'({A, B, ALU_Sel}), 32'd0);
        chk("rst_result", 32'({res_Out, res_Carry, res_Sel, res_DivZero}), 32'd0);
        chk("rst_cmd_count", 32'(cmd_count), 32'd0);

        // Single add: operands visible after accept edge, result one edge later.
        res_ready = 1'b1;
        drive(8'd20, 8'd22, 4'b0000);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("lat_operands", 32'({A, B, ALU_Sel}), 32'({8'd20, 8'd22, 4'd0}));
        chk("lat_not_yet_valid", 32'(res_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(res_valid), 32'd1);
        chk("add_42", 32'({res_Out, res_Sel, res_DivZero}), 32'({8'd42, 4'd0, 1'b0}));
        tick();
        chk("add_consumed", 32'(res_valid), 32'd0);

        // Divide by zero guard followed by a normal divide.
        drive(8'd100, 8'd0, 4'b0011);
        tick();
        drive(8'd100, 8'd5, 4'b0011);
        tick();
        cmd_valid = 1'b0;
        #1 chk("div0_guard", 32'({res_Out, res_Carry, res_DivZero}), 32'({8'hFF, 1'b0, 1'b1}));
        drain(10);

        // Back-pressure: five commands fill FIFO plus result register.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(8'(10 * i + 3), 8'(i + 1), 4'(i));
            tick();
        end
        cmd_valid = 1'b0;
        #1;
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_res_valid", 32'(res_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_stable", 32'({res_valid, res_Out}), 32'({1'b1, sb[0].out}));
        end
        res_ready = 1'b1;
        drive(8'd77, 8'd11, 4'd6);
        #1 chk("full_no_passthru", 32'(cmd_ready), 32'd0);
        tick();
        tick();
        cmd_valid = 1'b0;
        drain(10);
        #1 chk("bp_idle", 32'(res_valid), 32'd0);

        // Streaming: 20 commands at one per cycle, pointers wrap several times.
        for (int i = 0; i < 20; i++) begin
            drive(8'($urandom_range(0, 255)), (i % 5 == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                  4'($urandom_range(0, 7)));
            #1 chk("stream_ready", 32'(cmd_ready), 32'd1);
            if (i >= 2) chk("stream_valid", 32'(res_valid), 32'd1);
            tick();
        end
        cmd_valid = 1'b0;
        drain(10);

        // Reset while three commands are queued and one result is held.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'(i + 50), 8'(i + 2), 4'd0);
            tick();
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(res_valid), 32'd0);
        chk("async_rst_operands", 32'({A, B, ALU_Sel}), 32'd0);
        chk("async_rst_result", 32'({res_Out, res_Sel, res_DivZero}), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_quiet", 32'(res_valid), 32'd0);
        end

        // Statistics counter after exactly ten issues since reset.
        for (int i = 0; i < 10; i++) begin
            drive(8'(i * 7), 8'(i + 1), 4'(i % 8));
            tick();
        end
        cmd_valid = 1'b0;
        drain(10);
        #1 chk("cmd_count", 32'(cmd_count), 32'(EXP_COUNT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
